// File: rtl/lut_prog_pkg.sv
// Shared types and GPIO field positions for the LUT programming sequencer.
package lut_prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_A_HI,
    ST_A_LO,
    ST_D_HI,
    ST_D_LO,
    ST_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_HIGH,
    PH_LOW
  } strobe_phase_t;

  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = 8;
  localparam int WCLK_BIT = 16;

  // The LUT stores on the second data write after one auto-increment,
  // so the address register is loaded with one less than the target.
  function automatic logic [15:0] load_addr(input logic [15:0] base,
                                            input logic [15:0] idx);
    return base + idx - 16'd1;
  endfunction

endpackage

// File: rtl/gpio_byte_writer.sv
// Performs one GPIO register byte write: SETUP, then w_clk high and low for
// STROBE_HOLD cycles each, with address and data fields held throughout.
module gpio_byte_writer
  import lut_prog_pkg::*;
#(
  parameter int STROBE_HOLD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [7:0]  reg_addr,
  input  logic [7:0]  data_byte,
  output logic        byte_done,
  output logic [31:0] gpio_out
);

  localparam int HOLD_BITS = (STROBE_HOLD > 1) ? $clog2(STROBE_HOLD) : 1;
  localparam logic [HOLD_BITS-1:0] HOLD_LAST = HOLD_BITS'(STROBE_HOLD - 1);
  localparam logic [HOLD_BITS-1:0] HOLD_ONE  = HOLD_BITS'(1);

  strobe_phase_t        phase_q, phase_d;
  logic [HOLD_BITS-1:0] hold_q, hold_d;
  logic [7:0]           addr_q;
  logic [7:0]           byte_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= PH_IDLE;
      hold_q  <= '0;
      addr_q  <= '0;
      byte_q  <= '0;
    end else begin
      phase_q <= phase_d;
      hold_q  <= hold_d;
      if (go) begin
        addr_q <= reg_addr;
        byte_q <= data_byte;
      end
    end
  end

  // byte_done fires in the last LOW cycle so a following go starts the next
  // SETUP without a gap cycle.
  always_comb begin
    phase_d   = phase_q;
    hold_d    = hold_q;
    byte_done = 1'b0;
    case (phase_q)
      PH_SETUP: begin
        phase_d = PH_HIGH;
        hold_d  = '0;
      end
      PH_HIGH: begin
        if (hold_q == HOLD_LAST) begin
          phase_d = PH_LOW;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      PH_LOW: begin
        if (hold_q == HOLD_LAST) begin
          phase_d   = PH_IDLE;
          hold_d    = '0;
          byte_done = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        phase_d = PH_IDLE;
      end
    endcase
    if (go) begin
      phase_d = PH_SETUP;
      hold_d  = '0;
    end
  end

  always_comb begin
    gpio_out                 = '0;
    gpio_out[DATA_LSB +: 8]  = byte_q;
    gpio_out[ADDR_LSB +: 8]  = addr_q;
    gpio_out[WCLK_BIT]       = (phase_q == PH_HIGH);
  end

endmodule

// File: rtl/lut_prog_sequencer.sv
// Programs the 16-bit lookup table through its byte-wide GPIO port: each entry
// is two address-register byte writes followed by two data-register byte writes.
module lut_prog_sequencer
  import lut_prog_pkg::*;
#(
  parameter int ADDR_REG    = 0,
  parameter int DATA_REG    = 1,
  parameter int STROBE_HOLD = 2,
  parameter int CNT_BITS    = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         base_addr,
  input  logic [CNT_BITS-1:0] count,
  input  logic                abort,
  input  logic [15:0]         s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [31:0]         gpio_out,
  output logic                lut_busy,
  output logic                done,
  output logic                aborted
);

  localparam logic [7:0] ADDR_SEL = 8'(ADDR_REG);
  localparam logic [7:0] DATA_SEL = 8'(DATA_REG);

  seq_state_t          state_q, state_d;
  logic [15:0]         base_q;
  logic [CNT_BITS-1:0] count_q;
  logic [CNT_BITS-1:0] idx_q;
  logic [CNT_BITS-1:0] idx_next;
  logic [15:0]         entry_q;
  logic                abort_pend_q;
  logic                aborted_q;

  logic                go;
  logic [7:0]          wr_reg;
  logic [7:0]          wr_byte;
  logic                byte_done;
  logic                accept_start;
  logic                latch_entry;
  logic                idx_inc;
  logic                set_aborted;
  logic                end_run;
  logic                in_write;
  logic [15:0]         target_m1;

  assign idx_next  = idx_q + CNT_BITS'(1);
  assign target_m1 = load_addr(base_q, 16'(idx_q));
  assign end_run   = abort_pend_q || abort;
  assign in_write  = (state_q == ST_A_HI) || (state_q == ST_A_LO) ||
                     (state_q == ST_D_HI) || (state_q == ST_D_LO);

  gpio_byte_writer #(
    .STROBE_HOLD(STROBE_HOLD)
  ) u_writer (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .reg_addr (wr_reg),
    .data_byte(wr_byte),
    .byte_done(byte_done),
    .gpio_out (gpio_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      entry_q      <= '0;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        base_q       <= base_addr;
        count_q      <= count;
        idx_q        <= '0;
        abort_pend_q <= 1'b0;
        aborted_q    <= 1'b0;
      end else begin
        if (idx_inc) begin
          idx_q <= idx_next;
        end
        if (abort && in_write) begin
          abort_pend_q <= 1'b1;
        end else if (state_q == ST_DONE) begin
          abort_pend_q <= 1'b0;
        end
        if (set_aborted) begin
          aborted_q <= 1'b1;
        end
      end
      if (latch_entry) begin
        entry_q <= s_data;
      end
    end
  end

  // An abort seen during a byte write is deferred until byte_done so w_clk
  // always completes its LOW phase before the run ends.
  always_comb begin
    state_d      = state_q;
    go           = 1'b0;
    wr_reg       = ADDR_SEL;
    wr_byte      = target_m1[15:8];
    accept_start = 1'b0;
    latch_entry  = 1'b0;
    idx_inc      = 1'b0;
    set_aborted  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_d      = (count == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          state_d     = ST_DONE;
          set_aborted = 1'b1;
        end else if (s_valid) begin
          latch_entry = 1'b1;
          go          = 1'b1;
          wr_reg      = ADDR_SEL;
          wr_byte     = target_m1[15:8];
          state_d     = ST_A_HI;
        end
      end
      ST_A_HI: begin
        if (byte_done) begin
          if (end_run) begin
            state_d     = ST_DONE;
            set_aborted = 1'b1;
          end else begin
            go      = 1'b1;
            wr_reg  = ADDR_SEL;
            wr_byte = target_m1[7:0];
            state_d = ST_A_LO;
          end
        end
      end
      ST_A_LO: begin
        if (byte_done) begin
          if (end_run) begin
            state_d     = ST_DONE;
            set_aborted = 1'b1;
          end else begin
            go      = 1'b1;
            wr_reg  = DATA_SEL;
            wr_byte = entry_q[15:8];
            state_d = ST_D_HI;
          end
        end
      end
      ST_D_HI: begin
        if (byte_done) begin
          if (end_run) begin
            state_d     = ST_DONE;
            set_aborted = 1'b1;
          end else begin
            go      = 1'b1;
            wr_reg  = DATA_SEL;
            wr_byte = entry_q[7:0];
            state_d = ST_D_LO;
          end
        end
      end
      ST_D_LO: begin
        if (byte_done) begin
          idx_inc = 1'b1;
          if (end_run) begin
            state_d     = ST_DONE;
            set_aborted = 1'b1;
          end else if (idx_next == count_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s_ready  = (state_q == ST_FETCH);
  assign done     = (state_q == ST_DONE);
  assign lut_busy = (state_q != ST_IDLE);
  assign aborted  = aborted_q;

endmodule
